// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store engine between the datapath and a req/ack
// data-memory bus. Builds byte enables and lane-replicated write data, runs
// one bus transaction per access, formats load data (sign/zero extension) and
// stalls the pipeline until the access completes or times out.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (reject misaligned half/word
// accesses without touching the bus and pulse misalign_err).
module dmem_access_unit #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        load_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        timeout_err,
   output logic        misalign_err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t          state_reg;
   logic [TO_W-1:0] cnt_reg;
   logic [1:0]      lo_reg;
   logic [1:0]      size_reg;
   logic            uns_reg;
   logic            we_reg;

   logic [3:0]      be_next;
   logic [31:0]     wdata_next;
   logic [31:0]     fmt_data;
   logic [7:0]      rbyte [4];
   logic [7:0]      sel_byte;
   logic [15:0]     sel_half;

   // Split the read word into its four byte lanes (lane i = bits 8i+7:8i)
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign rbyte[gi] = bus_rdata[8*gi +: 8];
      end
   endgenerate

   // Byte enables and replicated write data for the access being requested
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = store_data;
      case (mem_size)
         2'b00: begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << {addr[1], 1'b0};
            wdata_next = {2{store_data[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = store_data;
         end
      endcase
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   logic misalign_next;

   // Half accesses must be 2-byte aligned, word accesses 4-byte aligned
   always_comb begin
      misalign_next = ((mem_size == 2'b01) && addr[0]) ||
                      (mem_size[1] && (addr[1:0] != 2'b00));
   end
`else
   assign misalign_err = 1'b0;
`endif

   // Lane selection and extension of the read word using the latched access
   always_comb begin
      sel_byte = rbyte[lo_reg];
      sel_half = lo_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size_reg)
         2'b00:   fmt_data = uns_reg ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         2'b01:   fmt_data = uns_reg ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
         default: fmt_data = bus_rdata;
      endcase
   end

   // Pipeline hold: from the request cycle until the bus access finishes
   assign stall = ((state_reg == IDLE) && (mem_read || mem_write)) || (state_reg == REQ);

   // Access FSM with registered bus outputs, load result and error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         lo_reg      <= 2'b00;
         size_reg    <= 2'b00;
         uns_reg     <= 1'b0;
         we_reg      <= 1'b0;
         load_data   <= 32'd0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= 32'd0;
         bus_wdata   <= 32'd0;
         bus_be      <= 4'd0;
         timeout_err <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         misalign_err <= 1'b0;
`endif
      end else begin
`ifdef DMEM_MISALIGN_CHECK_EN
         misalign_err <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (mem_read || mem_write) begin
                  lo_reg   <= addr[1:0];
                  size_reg <= mem_size;
                  uns_reg  <= load_unsigned;
                  we_reg   <= mem_write;
`ifdef DMEM_MISALIGN_CHECK_EN
                  if (misalign_next) begin
                     // Rejected access never reaches the bus
                     misalign_err <= 1'b1;
                     load_data    <= 32'd0;
                     state_reg    <= DONE;
                  end else begin
`else
                  begin
`endif
                     bus_req   <= 1'b1;
                     bus_we    <= mem_write;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_wdata <= wdata_next;
                     bus_be    <= be_next;
                     cnt_reg   <= '0;
                     state_reg <= REQ;
                  end
               end
            end
            REQ: begin
               if (bus_ack) begin
                  // Ack wins even in the cycle the timeout would fire
                  load_data <= we_reg ? 32'd0 : fmt_data;
                  bus_req   <= 1'b0;
                  state_reg <= DONE;
               end else if (cnt_reg == TO_W'(TIMEOUT - 1)) begin
                  load_data   <= 32'd0;
                  bus_req     <= 1'b0;
                  timeout_err <= 1'b1;
                  state_reg   <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               bus_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed testbench for dmem_access_unit (TIMEOUT=4); one line per transaction.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write, load_unsigned, bus_ack;
   logic [1:0]  mem_size;
   logic [31:0] addr, store_data, bus_rdata;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic        stall, bus_req, bus_we, timeout_err, misalign_err;
   logic [3:0]  bus_be;

   int n_checks = 0;
   int n_fails  = 0;

   dmem_access_unit #(.TIMEOUT(4), .TO_W(8)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .load_unsigned(load_unsigned), .addr(addr), .store_data(store_data),
      .load_data(load_data), .stall(stall),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .timeout_err(timeout_err), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] sd);
      mem_read = rd; mem_write = wr; mem_size = sz;
      load_unsigned = uns; addr = a; store_data = sd;
   endtask

   task automatic idle_inputs();
      mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
      req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("rst_misalign_err", {31'd0, misalign_err}, 32'd0);
      $display("txn reset: stall=%0b bus_req=%0b load_data=0x%08h", stall, bus_req, load_data);

      // Word load, zero-wait ack
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
      #1 chk("wl_stall_idle", {31'd0, stall}, 32'd1);
      tick();
      chk("wl_stall_req", {31'd0, stall}, 32'd1);
      chk("wl_bus_req", {31'd0, bus_req}, 32'd1);
      chk("wl_bus_addr", bus_addr, 32'h10);
      chk("wl_bus_be", {28'd0, bus_be}, 32'hF);
      chk("wl_bus_we", {31'd0, bus_we}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
      tick();
      chk("wl_load_data", load_data, 32'hDEADBEEF);
      chk("wl_stall_done", {31'd0, stall}, 32'd0);
      chk("wl_bus_req_done", {31'd0, bus_req}, 32'd0);
      $display("txn word load 0x10: load_data=0x%08h", load_data);
      idle_inputs(); tick();

      // Byte load signed, lane 3
      req(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
      tick();
      chk("lbs_bus_be", {28'd0, bus_be}, 32'h8);
      chk("lbs_bus_addr", bus_addr, 32'h10);
      bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
      tick();
      chk("lbs_load_data", load_data, 32'hFFFFFF80);
      $display("txn byte load signed 0x13: load_data=0x%08h", load_data);
      idle_inputs(); tick();

      // Same byte load unsigned
      req(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
      tick();
      bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
      tick();
      chk("lbu_load_data", load_data, 32'h00000080);
      $display("txn byte load unsigned 0x13: load_data=0x%08h", load_data);
      idle_inputs(); tick();

      // Half store to upper half
      req(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD);
      tick();
      chk("sh_bus_be", {28'd0, bus_be}, 32'hC);
      chk("sh_bus_wdata", bus_wdata, 32'hABCDABCD);
      chk("sh_bus_we", {31'd0, bus_we}, 32'd1);
      chk("sh_bus_addr", bus_addr, 32'h20);
      bus_ack = 1'b1;
      tick();
      chk("sh_load_data", load_data, 32'd0);
      $display("txn half store 0x22: be=%04b wdata=0x%08h", bus_be, bus_wdata);
      idle_inputs(); tick();

      // Byte store lane 1
      req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A);
      tick();
      chk("sb_bus_be", {28'd0, bus_be}, 32'h2);
      chk("sb_bus_wdata", bus_wdata, 32'h5A5A5A5A);
      bus_ack = 1'b1;
      tick();
      $display("txn byte store 0x11: be=%04b wdata=0x%08h", bus_be, bus_wdata);
      idle_inputs(); tick();

      // Half load signed upper half with one wait cycle
      req(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
      tick();
      bus_rdata = 32'h8001_1234;
      tick();
      chk("lhs_wait_stall", {31'd0, stall}, 32'd1);
      chk("lhs_wait_bus_req", {31'd0, bus_req}, 32'd1);
      bus_ack = 1'b1;
      tick();
      chk("lhs_load_data", load_data, 32'hFFFF8001);
      $display("txn half load signed 0x22: load_data=0x%08h", load_data);
      idle_inputs(); tick();

      // Half load unsigned lower half
      req(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'd0);
      tick();
      bus_ack = 1'b1; bus_rdata = 32'h8001_F234;
      tick();
      chk("lhu_load_data", load_data, 32'h0000F234);
      $display("txn half load unsigned 0x20: load_data=0x%08h", load_data);
      idle_inputs(); tick();

      // Ack outside REQ ignored
      bus_ack = 1'b1; bus_rdata = 32'h55555555;
      tick();
      bus_ack = 1'b0;
      chk("stray_ack_load_data", load_data, 32'h0000F234);
      $display("txn stray ack: load_data=0x%08h", load_data);

      // Timeout: no ack
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_bus_req_%0d", i), {31'd0, bus_req}, 32'd1);
         tick();
      end
      chk("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
      chk("to_timeout_err", {31'd0, timeout_err}, 32'd1);
      chk("to_load_data", load_data, 32'd0);
      chk("to_stall", {31'd0, stall}, 32'd0);
      idle_inputs(); tick(); tick();
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);
      $display("txn timeout 0x40: timeout_err=%0b load_data=0x%08h", timeout_err, load_data);

      // Reset during REQ
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'd0);
      tick();
      chk("rr_bus_req_pre", {31'd0, bus_req}, 32'd1);
      rst = 1'b1; idle_inputs();
      tick();
      rst = 1'b0;
      chk("rr_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rr_stall", {31'd0, stall}, 32'd0);
      chk("rr_timeout_err", {31'd0, timeout_err}, 32'd0);
      tick();
      chk("rr_idle_bus_req", {31'd0, bus_req}, 32'd0);
      $display("txn reset in REQ: bus_req=%0b stall=%0b", bus_req, stall);

      // Misaligned word load at 0x11
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'd0);
      tick();
`ifdef DMEM_MISALIGN_CHECK_EN
      chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_load_data", load_data, 32'd0);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      idle_inputs(); tick();
      chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
`else
      chk("mis_bus_req", {31'd0, bus_req}, 32'd1);
      chk("mis_bus_addr", bus_addr, 32'h10);
      chk("mis_err", {31'd0, misalign_err}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h01020304;
      tick();
      chk("mis_load_data", load_data, 32'h01020304);
      chk("mis_err_done", {31'd0, misalign_err}, 32'd0);
      idle_inputs(); tick();
`endif
      $display("txn misaligned word 0x11: misalign_err=%0b bus_addr=0x%08h", misalign_err, bus_addr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Absolute bound so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
